project: RTL and testbench
==========================

PROJECT -- requirements
Module: project

Interface
REQ-001: The block SHALL have no parameters; address width 12, data width 16, kernel 3x3 fixed.
REQ-002: clk  input  1  single clock; all state changes on rising edge.
REQ-003: reset_b  input  1  asynchronous, active-low reset.
REQ-004: dut_run  input  1  start request from host.
REQ-005: dut_busy  output  1  high while a job is in progress.
REQ-006: dut_sram_read_address  output  12  input-memory read address.
REQ-007: sram_dut_read_data  input  16  input-memory read data, valid the cycle after the address is presented (registered read).
REQ-008: dut_wmem_read_address  output  12  weight-memory read address.
REQ-009: wmem_dut_read_data  input  16  weight-memory read data, same one-cycle latency.
REQ-010: dut_sram_write_enable  output  1  output-memory write strobe, one cycle per result.
REQ-011: dut_sram_write_address  output  12  output-memory write address.
REQ-012: dut_sram_write_data  output  16  output-memory write data.

Function
REQ-013: Weight memory SHALL hold a signed 16-bit 3x3 kernel w[i][j] at address 3*i+j (addresses 0..8).
REQ-014: Input memory SHALL hold consecutive matrices starting at address 0; each matrix is one header word N followed by N*N signed 16-bit elements, row-major: element (r,c) at H+1+N*r+c, where H is the header address; the next header is at H+1+N*N.
REQ-015: A header equal to 16'h00FF SHALL terminate the job; N values 3..16 SHALL be supported.
REQ-016: For each matrix, the block SHALL compute (N-2)^2 valid-convolution results out[r][c] = sum over i,j in 0..2 of in[r+i][c+j]*w[i][j], for r,c in 0..N-3.
REQ-017: Products SHALL be full 32-bit signed; accumulation SHALL use at least 36 bits signed; the written value SHALL be the low 16 bits of the sum (wrap, no saturation).
REQ-018: Results SHALL be written in row-major order per matrix, matrices in input order, to consecutive output addresses starting at 0 and never resetting between matrices in a job; each new job restarts at address 0.
REQ-019: Each result SHALL be written by asserting dut_sram_write_enable for exactly one cycle with valid address and data; write_enable SHALL be low otherwise.
REQ-020: States: IDLE, LOAD_W (fetch 9 weights), READ_HDR, CHECK_HDR, CONV (fetch 9 window elements and accumulate), WRITE, NEXT (advance column/row/matrix), DONE.
REQ-021: IDLE -> LOAD_W when dut_run is sampled high; dut_busy SHALL rise on the first clock edge after that sample and stay high until the last result is written.
REQ-022: CHECK_HDR -> DONE when header is 16'h00FF, otherwise -> CONV; after the last window of a matrix, NEXT -> READ_HDR at H+1+N*N.
REQ-023: DONE -> IDLE in one cycle; dut_busy SHALL fall on entry to IDLE, after the final write has completed.
REQ-024: dut_run SHALL be ignored while busy; holding dut_run high after the job ends SHALL start a new job.
REQ-025: A job whose first header is 16'h00FF SHALL perform no writes and SHALL drop dut_busy within 20 cycles.
REQ-026: Read addresses SHALL account for the one-cycle memory read latency; data SHALL be captured the cycle after the address is driven.

Reset
REQ-027: While reset_b is low: state IDLE, dut_busy=0, dut_sram_write_enable=0, all address/data outputs 0, weights, accumulator and counters cleared.
REQ-028: Reset asserted mid-job SHALL abort immediately with no further writes; after release the block SHALL wait in IDLE for dut_run.

Verification
REQ-029: One matrix N=3 all elements 1, weights 1..9, terminator at address 10 -> single write addr 0 data 16'h002D; busy then low.
REQ-030: N=4 elements 0..15, weights w[1][1]=1 others 0 -> writes addr 0..3 data 5,6,9,10.
REQ-031: Matrices N=10, N=6, N=6 then terminator -> 96 writes at addresses 0..95 matching a software convolution model, none beyond 95.
REQ-032: N=3 elements 16'h7FFF, weights 16'h7FFF -> write data 16'h0009 (wrap); elements 16'hFFFF, weights 2 -> 16'hFFEE.
REQ-033: Header 16'h00FF at address 0 -> busy pulses, no write strobes; second dut_run then runs a normal job from address 0.
REQ-034: Assert reset_b low during CONV of a multi-matrix job -> busy and write_enable drop at once; rerun produces full correct output.

Source files
------------

// File: rtl/project.sv
// 3x3 valid-convolution engine over a stream of square matrices.
//
// Purpose: loads a signed 3x3 kernel from weight memory. It then walks the
// matrices held in input memory (header word N, then N*N row-major elements)
// until it reads a 16'h00FF header. Each (N-2)^2 window result is written to
// output memory at consecutive addresses starting at 0.
//
// Ports:
//   clk                     single clock, rising edge
//   reset_b                 asynchronous active-low reset
//   dut_run                 start request, sampled only in IDLE
//   dut_busy                high from the edge after start until back in IDLE
//   dut_sram_read_address   input-memory address (data returns next cycle)
//   sram_dut_read_data      input-memory read data
//   dut_wmem_read_address   weight-memory address (data returns next cycle)
//   wmem_dut_read_data      weight-memory read data
//   dut_sram_write_enable   one-cycle strobe per result
//   dut_sram_write_address  result address
//   dut_sram_write_data     result data (low 16 bits of the 36-bit sum)
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for dut_run
// LOAD_W    | fetch 9 weights; cnt 0..8 drives address, cnt 1..9 captures
// READ_HDR  | present header address
// CHECK_HDR | header data valid: terminate or start first window
// CONV      | fetch 9 window elements; cnt 1..9 accumulates
// WRITE     | strobe the result
// NEXT      | advance column / row / matrix
// DONE      | one cycle before returning to IDLE

module project (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        dut_run,
    output logic        dut_busy,
    output logic [11:0] dut_sram_read_address,
    input  logic [15:0] sram_dut_read_data,
    output logic [11:0] dut_wmem_read_address,
    input  logic [15:0] wmem_dut_read_data,
    output logic        dut_sram_write_enable,
    output logic [11:0] dut_sram_write_address,
    output logic [15:0] dut_sram_write_data
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD_W    = 3'd1;
    localparam logic [2:0] S_READ_HDR  = 3'd2;
    localparam logic [2:0] S_CHECK_HDR = 3'd3;
    localparam logic [2:0] S_CONV      = 3'd4;
    localparam logic [2:0] S_WRITE     = 3'd5;
    localparam logic [2:0] S_NEXT      = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    localparam logic [15:0] HDR_END = 16'h00FF;

    logic [2:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [11:0]        hdr_q, hdr_d;
    logic [4:0]         n_q, n_d;
    logic [3:0]         row_q, row_d;
    logic [3:0]         col_q, col_d;
    logic signed [35:0] acc_q, acc_d;
    logic [11:0]        out_addr_q, out_addr_d;
    logic signed [15:0] w_q [0:8];

    logic               w_we;
    logic [3:0]         w_idx;
    logic [1:0]         win_i, win_j;
    logic [11:0]        win_row, row_off, elem_addr, n_sq;
    logic signed [31:0] prod;
    logic               last_col, last_row;

    // Kernel position of the element whose address is presented at cnt_q.
    always_comb begin
        win_i = 2'd0;
        win_j = 2'd0;
        case (cnt_q)
            4'd1: win_j = 2'd1;
            4'd2: win_j = 2'd2;
            4'd3: win_i = 2'd1;
            4'd4: begin win_i = 2'd1; win_j = 2'd1; end
            4'd5: begin win_i = 2'd1; win_j = 2'd2; end
            4'd6: win_i = 2'd2;
            4'd7: begin win_i = 2'd2; win_j = 2'd1; end
            4'd8: begin win_i = 2'd2; win_j = 2'd2; end
            default: ;
        endcase
    end

    assign win_row   = {8'd0, row_q} + {10'd0, win_i};
    assign row_off   = {7'd0, n_q} * win_row;
    assign elem_addr = hdr_q + 12'd1 + row_off + {8'd0, col_q} + {10'd0, win_j};
    assign n_sq      = {7'd0, n_q} * {7'd0, n_q};

    // Returning data belongs to the address presented one count earlier.
    assign w_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    assign prod  = $signed(sram_dut_read_data) * w_q[w_idx];

    assign last_col = ({1'b0, col_q} == (n_q - 5'd3));
    assign last_row = ({1'b0, row_q} == (n_q - 5'd3));

    assign dut_busy               = (state_q != S_IDLE);
    assign dut_sram_write_enable  = (state_q == S_WRITE);
    assign dut_sram_write_address = (state_q == S_WRITE) ? out_addr_q : 12'd0;
    assign dut_sram_write_data    = (state_q == S_WRITE) ? acc_q[15:0] : 16'd0;
    assign dut_wmem_read_address  = (state_q == S_LOAD_W && cnt_q < 4'd9) ? {8'd0, cnt_q} : 12'd0;

    always_comb begin
        dut_sram_read_address = 12'd0;
        if (state_q == S_READ_HDR)
            dut_sram_read_address = hdr_q;
        else if (state_q == S_CONV && cnt_q < 4'd9)
            dut_sram_read_address = elem_addr;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hdr_d      = hdr_q;
        n_d        = n_q;
        row_d      = row_q;
        col_d      = col_q;
        acc_d      = acc_q;
        out_addr_d = out_addr_q;
        w_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dut_run) begin
                    state_d    = S_LOAD_W;
                    cnt_d      = 4'd0;
                    hdr_d      = 12'd0;
                    out_addr_d = 12'd0;
                end
            end
            S_LOAD_W: begin
                w_we  = (cnt_q != 4'd0);
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    cnt_d   = 4'd0;
                    state_d = S_READ_HDR;
                end
            end
            S_READ_HDR: state_d = S_CHECK_HDR;
            S_CHECK_HDR: begin
                if (sram_dut_read_data == HDR_END) begin
                    state_d = S_DONE;
                end else begin
                    n_d     = sram_dut_read_data[4:0];
                    row_d   = 4'd0;
                    col_d   = 4'd0;
                    cnt_d   = 4'd0;
                    acc_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                if (cnt_q != 4'd0)
                    acc_d = acc_q + {{4{prod[31]}}, prod};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9)
                    state_d = S_WRITE;
            end
            S_WRITE: begin
                out_addr_d = out_addr_q + 12'd1;
                state_d    = S_NEXT;
            end
            S_NEXT: begin
                cnt_d   = 4'd0;
                acc_d   = '0;
                state_d = S_CONV;
                if (!last_col) begin
                    col_d = col_q + 4'd1;
                end else begin
                    col_d = 4'd0;
                    if (!last_row) begin
                        row_d = row_q + 4'd1;
                    end else begin
                        hdr_d   = hdr_q + 12'd1 + n_sq;
                        state_d = S_READ_HDR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            hdr_q      <= 12'd0;
            n_q        <= 5'd0;
            row_q      <= 4'd0;
            col_q      <= 4'd0;
            acc_q      <= '0;
            out_addr_q <= 12'd0;
            for (int k = 0; k < 9; k++)
                w_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hdr_q      <= hdr_d;
            n_q        <= n_d;
            row_q      <= row_d;
            col_q      <= col_d;
            acc_q      <= acc_d;
            out_addr_q <= out_addr_d;
            if (w_we)
                w_q[w_idx] <= $signed(wmem_dut_read_data);
        end
    end

endmodule

// File: tb/tb_project.sv
module tb_project;

    logic        clk;
    logic        reset_b;
    logic        dut_run;
    logic        dut_busy;
    logic [11:0] dut_sram_read_address;
    logic [15:0] sram_dut_read_data;
    logic [11:0] dut_wmem_read_address;
    logic [15:0] wmem_dut_read_data;
    logic        dut_sram_write_enable;
    logic [11:0] dut_sram_write_address;
    logic [15:0] dut_sram_write_data;

    project dut (
        .clk                    (clk),
        .reset_b                (reset_b),
        .dut_run                (dut_run),
        .dut_busy               (dut_busy),
        .dut_sram_read_address  (dut_sram_read_address),
        .sram_dut_read_data     (sram_dut_read_data),
        .dut_wmem_read_address  (dut_wmem_read_address),
        .wmem_dut_read_data     (wmem_dut_read_data),
        .dut_sram_write_enable  (dut_sram_write_enable),
        .dut_sram_write_address (dut_sram_write_address),
        .dut_sram_write_data    (dut_sram_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem  [0:4095];
    logic [15:0] wmem [0:15];
    logic [15:0] out_mem [0:4095];
    logic [15:0] exp_q [$];

    int checks = 0;
    int failures = 0;
    int total_writes = 0;
    int job_writes = 0;
    int ord_err = 0;
    int dbl_err = 0;
    logic prev_busy = 1'b0;
    logic prev_we = 1'b0;

    // Registered-read memories.
    always @(posedge clk) begin
        sram_dut_read_data <= mem[dut_sram_read_address];
        wmem_dut_read_data <= wmem[dut_wmem_read_address[3:0]];
    end

    // Output memory capture; job_writes restarts whenever busy rises.
    always @(posedge clk) begin
        if (dut_busy && !prev_busy) job_writes = 0;
        prev_busy = dut_busy;
        if (dut_sram_write_enable) begin
            if (dut_sram_write_address != job_writes[11:0]) ord_err++;
            if (prev_we) dbl_err++;
            out_mem[dut_sram_write_address] = dut_sram_write_data;
            job_writes++;
            total_writes++;
        end
        prev_we = dut_sram_write_enable;
    end

    task automatic clear_mem();
        for (int k = 0; k < 4096; k++) begin
            mem[k] = 16'h0;
            out_mem[k] = 16'hDEAD;
        end
        for (int k = 0; k < 16; k++) wmem[k] = 16'h0;
    endtask

    task automatic clear_capture();
        total_writes = 0;
        ord_err = 0;
        dbl_err = 0;
        for (int k = 0; k < 4096; k++) out_mem[k] = 16'hDEAD;
    endtask

    // Software convolution model walking the input memory image.
    task automatic build_expected();
        int h;
        int n;
        longint s;
        exp_q.delete();
        h = 0;
        while (mem[h] != 16'h00FF && h < 4000) begin
            n = int'(mem[h]);
            for (int r = 0; r <= n - 3; r++)
                for (int c = 0; c <= n - 3; c++) begin
                    s = 0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            s += longint'($signed(mem[h + 1 + n * (r + i) + c + j]))
                               * longint'($signed(wmem[3 * i + j]));
                    exp_q.push_back(s[15:0]);
                end
            h = h + 1 + n * n;
        end
    endtask

    task automatic run_job(input int limit, output int cyc, output logic busy_start, output logic to);
        @(negedge clk);
        dut_run = 1'b1;
        @(negedge clk);
        dut_run = 1'b0;
        busy_start = dut_busy;
        cyc = 1;
        while (dut_busy && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        to = dut_busy;
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        dut_run = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", dut_busy); end
        checks++;
        if (dut_sram_write_enable !== 1'b0) begin failures++; $display("FAIL reset_we got %b want 0", dut_sram_write_enable); end
        checks++;
        if ({dut_sram_read_address, dut_wmem_read_address, dut_sram_write_address} !== 36'h0) begin
            failures++; $display("FAIL reset_addr got %h %h %h want 0", dut_sram_read_address, dut_wmem_read_address, dut_sram_write_address);
        end
        checks++;
        if (dut_sram_write_data !== 16'h0) begin failures++; $display("FAIL reset_wdata got %h want 0000", dut_sram_write_data); end
        @(negedge clk);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (dut_busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy got %b want 0", dut_busy); end
    endtask

    task automatic test_ones();
        int cyc;
        logic bs, to;
        clear_mem();
        mem[0] = 16'd3;
        for (int k = 1; k <= 9; k++) mem[k] = 16'd1;
        mem[10] = 16'h00FF;
        for (int k = 0; k < 9; k++) wmem[k] = 16'(k + 1);
        clear_capture();
        run_job(500, cyc, bs, to);
        checks++;
        if (bs !== 1'b1) begin failures++; $display("FAIL ones_busy_rise got %b want 1", bs); end
        checks++;
        if (to) begin failures++; $display("FAIL ones_timeout busy still %b after %0d cycles", dut_busy, cyc); end
        checks++;
        if (total_writes != 1) begin failures++; $display("FAIL ones_count got %0d want 1", total_writes); end
        checks++;
        if (out_mem[0] !== 16'h002D) begin failures++; $display("FAIL ones_data got %h want 002d", out_mem[0]); end
    endtask

    task automatic test_center();
        int cyc;
        logic bs, to;
        logic [15:0] want [4];
        want = '{16'd5, 16'd6, 16'd9, 16'd10};
        clear_mem();
        mem[0] = 16'd4;
        for (int k = 0; k < 16; k++) mem[1 + k] = 16'(k);
        mem[17] = 16'h00FF;
        wmem[4] = 16'd1;
        clear_capture();
        run_job(500, cyc, bs, to);
        checks++;
        if (to || total_writes != 4 || ord_err != 0 || dbl_err != 0) begin
            failures++; $display("FAIL center_writes got count=%0d ord=%0d dbl=%0d to=%b want 4/0/0/0", total_writes, ord_err, dbl_err, to);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_mem[k] !== want[k]) begin failures++; $display("FAIL center_data[%0d] got %h want %h", k, out_mem[k], want[k]); end
        end
    endtask

    task automatic load_multi();
        clear_mem();
        mem[0] = 16'd10;
        for (int k = 1; k <= 100; k++) mem[k] = 16'($urandom);
        mem[101] = 16'd6;
        for (int k = 102; k <= 137; k++) mem[k] = 16'($urandom);
        mem[138] = 16'd6;
        for (int k = 139; k <= 174; k++) mem[k] = 16'($urandom_range(0, 255));
        mem[175] = 16'h00FF;
        for (int k = 0; k < 9; k++) wmem[k] = 16'($urandom);
        build_expected();
    endtask

    task automatic check_multi(input string tag);
        checks++;
        if (total_writes != 96 || ord_err != 0 || dbl_err != 0) begin
            failures++; $display("FAIL %s_writes got count=%0d ord=%0d dbl=%0d want 96/0/0", tag, total_writes, ord_err, dbl_err);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (out_mem[k] !== exp_q[k]) begin failures++; $display("FAIL %s_data[%0d] got %h want %h", tag, k, out_mem[k], exp_q[k]); end
        end
        checks++;
        if (out_mem[96] !== 16'hDEAD) begin failures++; $display("FAIL %s_beyond95 got %h want untouched dead", tag, out_mem[96]); end
    endtask

    task automatic test_multi();
        int cyc;
        logic bs, to;
        load_multi();
        clear_capture();
        run_job(5000, cyc, bs, to);
        checks++;
        if (to) begin failures++; $display("FAIL multi_timeout busy %b after %0d cycles", dut_busy, cyc); end
        check_multi("multi");
    endtask

    task automatic test_wrap();
        int cyc;
        logic bs, to;
        clear_mem();
        mem[0] = 16'd3;
        for (int k = 1; k <= 9; k++) mem[k] = 16'h7FFF;
        mem[10] = 16'h00FF;
        for (int k = 0; k < 9; k++) wmem[k] = 16'h7FFF;
        clear_capture();
        run_job(500, cyc, bs, to);
        checks++;
        if (to || total_writes != 1 || out_mem[0] !== 16'h0009) begin
            failures++; $display("FAIL wrap_pos got %h count=%0d want 0009 count=1", out_mem[0], total_writes);
        end
        for (int k = 1; k <= 9; k++) mem[k] = 16'hFFFF;
        for (int k = 0; k < 9; k++) wmem[k] = 16'd2;
        clear_capture();
        run_job(500, cyc, bs, to);
        checks++;
        if (to || total_writes != 1 || out_mem[0] !== 16'hFFEE) begin
            failures++; $display("FAIL wrap_neg got %h count=%0d want ffee count=1", out_mem[0], total_writes);
        end
    endtask

    task automatic test_empty_job();
        int cyc;
        logic bs, to;
        clear_mem();
        mem[0] = 16'h00FF;
        for (int k = 0; k < 9; k++) wmem[k] = 16'(k + 1);
        clear_capture();
        run_job(100, cyc, bs, to);
        checks++;
        if (bs !== 1'b1) begin failures++; $display("FAIL empty_busy_pulse got %b want 1", bs); end
        checks++;
        if (to || cyc > 20) begin failures++; $display("FAIL empty_duration got %0d cycles want <=20", cyc); end
        checks++;
        if (total_writes != 0) begin failures++; $display("FAIL empty_writes got %0d want 0", total_writes); end
        mem[0] = 16'd3;
        for (int k = 1; k <= 9; k++) mem[k] = 16'd1;
        mem[10] = 16'h00FF;
        clear_capture();
        run_job(500, cyc, bs, to);
        checks++;
        if (to || total_writes != 1 || out_mem[0] !== 16'h002D) begin
            failures++; $display("FAIL empty_rerun got %h count=%0d want 002d count=1", out_mem[0], total_writes);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        clear_mem();
        mem[0] = 16'd3;
        for (int k = 1; k <= 9; k++) mem[k] = 16'd1;
        mem[10] = 16'h00FF;
        for (int k = 0; k < 9; k++) wmem[k] = 16'(k + 1);
        clear_capture();
        @(negedge clk);
        dut_run = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (dut_busy && cyc < 500) begin @(negedge clk); cyc++; end
        checks++;
        if (dut_busy !== 1'b0) begin failures++; $display("FAIL b2b_first_end busy got %b want 0", dut_busy); end
        @(negedge clk);
        checks++;
        if (dut_busy !== 1'b1) begin failures++; $display("FAIL b2b_restart busy got %b want 1", dut_busy); end
        dut_run = 1'b0;
        cyc = 0;
        while (dut_busy && cyc < 500) begin @(negedge clk); cyc++; end
        checks++;
        if (dut_busy || total_writes != 2 || ord_err != 0 || out_mem[0] !== 16'h002D) begin
            failures++; $display("FAIL b2b_writes got count=%0d ord=%0d data=%h want 2/0/002d", total_writes, ord_err, out_mem[0]);
        end
    endtask

    task automatic test_reset_midjob();
        int cyc;
        int saved;
        logic bs, to;
        load_multi();
        clear_capture();
        @(negedge clk);
        dut_run = 1'b1;
        @(negedge clk);
        dut_run = 1'b0;
        cyc = 0;
        while (total_writes < 10 && cyc < 3000) begin @(negedge clk); cyc++; end
        checks++;
        if (total_writes < 10) begin failures++; $display("FAIL midrst_progress got %0d writes want >=10", total_writes); end
        repeat (3) @(negedge clk);
        reset_b = 1'b0;
        #1;
        checks++;
        if (dut_busy !== 1'b0 || dut_sram_write_enable !== 1'b0) begin
            failures++; $display("FAIL midrst_drop busy=%b we=%b want 0 0", dut_busy, dut_sram_write_enable);
        end
        saved = total_writes;
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (dut_busy !== 1'b0 || total_writes != saved) begin
            failures++; $display("FAIL midrst_idle busy=%b writes=%0d want 0 %0d", dut_busy, total_writes, saved);
        end
        clear_capture();
        run_job(5000, cyc, bs, to);
        checks++;
        if (to) begin failures++; $display("FAIL midrst_timeout busy %b after %0d cycles", dut_busy, cyc); end
        check_multi("midrst");
    endtask

    initial begin
        reset_b = 1'b0;
        dut_run = 1'b0;
        clear_mem();
        test_reset();
        test_ones();
        test_center();
        test_multi();
        test_wrap();
        test_empty_job();
        test_back_to_back();
        test_reset_midjob();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
